encode_seq: RTL and testbench
=============================

ENCODE_SEQ -- requirements
Module: encode_seq

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  one-cycle request to encode one 8x8 message block; honoured only in IDLE.
REQ-004 level  input  2  security level: 2'b01=1344 (B=4), 2'b10=976 (B=3), 2'b11=640 (B=2), 2'b00 invalid; sampled when start is honoured.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse after the last C beat is accepted.
REQ-007 err  output  1  one-cycle pulse when start arrives in IDLE with level=2'b00.
REQ-008 msg_rd_en  output  1  message memory read strobe.
REQ-009 msg_rd_addr  output  2  message word address (64-bit words).
REQ-010 msg_rd_data  input  64  read data, valid exactly 1 cycle after msg_rd_en.
REQ-011 v_valid / v_ready  input / output  1 / 1  handshake for V words (4 x 16-bit lanes, lane 0 = bits 15:0).
REQ-012 v_data  input  64  four V coefficients.
REQ-013 c_valid / c_ready  output / input  1 / 1  handshake for C words.
REQ-014 c_data  output  64  four C coefficients, same lane order.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN, FIN; FIN lasts one cycle, then IDLE.
REQ-016 IDLE->LOAD on start with valid level; start with level=2'b00 SHALL pulse err and stay in IDLE; start outside IDLE SHALL be ignored.
REQ-017 LOAD SHALL issue B consecutive reads, addr 0..B-1, one per cycle, and place word k into bits [64k+63:64k] of a 256-bit message buffer.
REQ-018 LOAD->RUN on the cycle the last read data is captured (LOAD lasts B+1 cycles).
REQ-019 In RUN, group g (0..15) SHALL use buffer bits [4Bg+4B-1:4Bg]; lane i takes the B bits at offset B*i within the group.
REQ-020 Each lane's B bits SHALL be expanded by the existing Encode datapath (en=1, latched level): B=4 -> bits<<12, B=3 -> bits<<13, B=2 -> bits<<13 with bit 15=0.
REQ-021 c_data lane SHALL be (v_data lane + encoded lane) mod 2^16; for level 2'b11 bit 15 of every lane SHALL be forced 0 (mod 2^15).
REQ-022 v_ready SHALL be high only in RUN when (!c_valid || c_ready) and fewer than 16 V beats have been accepted.
REQ-023 A V beat is accepted on v_valid && v_ready; result SHALL be registered into c_data with c_valid=1 the next cycle (latency 1), group counter incremented.
REQ-024 c_valid/c_data SHALL hold stable until c_ready; simultaneous C accept and new V accept SHALL give back-to-back C beats at one per cycle.
REQ-025 After the 16th C beat is accepted the FSM SHALL enter FIN, pulsing done.
REQ-026 The group counter is 4 bits and SHALL not wrap within a block; it clears on entry to LOAD.

Reset
REQ-027 rst_n low SHALL, at any time including mid-block, force IDLE, busy=0, done=0, err=0, msg_rd_en=0, msg_rd_addr=0, v_ready=0, c_valid=0, c_data=0, counters and buffer 0; the partial block is discarded.

Structure
REQ-028 Level codes, per-level B and word-count constants, and FSM state encoding SHALL live in the shared Frodo parameter package.
REQ-029 One sub-module: the existing Encode datapath, instantiated once (4 lanes), combinational, fed from the current group slice.

Verification
REQ-030 level=2'b01, message words all 0xFFFF_FFFF_FFFF_FFFF, V all 0x0001 -> 16 C beats each lane 0xF001, done 1 cycle after last accept, 4 reads.
REQ-031 level=2'b11, message word0 bits[7:0]=0xE4, V lanes 0x7FFF -> first C beat lanes 0x7FFF,0x1FFF,0x3FFF,0x5FFF (bit 15 cleared), 2 reads only.
REQ-032 level=2'b10, c_ready held low 5 cycles mid-block -> c_data stable, v_ready low, no beat lost or duplicated, exactly 16 beats.
REQ-033 start with level=2'b00 -> err pulse, busy stays 0, no msg_rd_en; start during RUN -> ignored.
REQ-034 rst_n asserted after 7 C beats -> all outputs at reset values immediately; subsequent start completes a full 16-beat block.
REQ-035 c_ready and v_valid tied high -> 16 consecutive C beats with no bubbles.

Source files
------------

// File: rtl/encode_seq_pkg.sv
// rtl/encode_seq_pkg.sv - shared Frodo level codes, sizes and FSM encoding
package encode_seq_pkg;

  localparam logic [1:0] LVL_INVALID = 2'b00;
  localparam logic [1:0] LVL_1344    = 2'b01;
  localparam logic [1:0] LVL_976     = 2'b10;
  localparam logic [1:0] LVL_640     = 2'b11;

  localparam int NUM_GROUPS    = 16;
  localparam int MSG_WORDS_MAX = 4;
  localparam int MSG_BITS      = 64 * MSG_WORDS_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  // B: bits per coefficient, which is also the number of 64-bit message words
  function automatic logic [2:0] level_words(input logic [1:0] lvl);
    case (lvl)
      LVL_1344: return 3'd4;
      LVL_976:  return 3'd3;
      LVL_640:  return 3'd2;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/encode_seq_encode.sv
// rtl/encode_seq_encode.sv - combinational Encode datapath, four 16-bit lanes
module encode_seq_encode
  import encode_seq_pkg::*;
(
  input  logic        en,
  input  logic [1:0]  level,
  input  logic [15:0] slice,
  output logic [63:0] enc
);

  always_comb begin
    enc = '0;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        case (level)
          LVL_1344: enc[16*i +: 16] = {slice[4*i +: 4], 12'h000};
          LVL_976:  enc[16*i +: 16] = {slice[3*i +: 3], 13'h0000};
          LVL_640:  enc[16*i +: 16] = {1'b0, slice[2*i +: 2], 13'h0000};
          default:  enc[16*i +: 16] = 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: rtl/encode_seq.sv
// rtl/encode_seq.sv - loads one message block, then encodes 16 V beats into C beats
module encode_seq
  import encode_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  level,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        msg_rd_en,
  output logic [1:0]  msg_rd_addr,
  input  logic [63:0] msg_rd_data,
  input  logic        v_valid,
  output logic        v_ready,
  input  logic [63:0] v_data,
  output logic        c_valid,
  input  logic        c_ready,
  output logic [63:0] c_data
);

  state_t                state;
  logic [1:0]            lvl_q;
  logic [2:0]            words_q;
  logic [2:0]            ld_cnt;
  logic [3:0]            grp;
  logic [3:0]            c_cnt;
  logic                  v_all;
  logic [MSG_BITS-1:0]   msg_buf;
  logic [7:0]            grp_off;
  logic [15:0]           slice;
  logic [63:0]           enc;
  logic [63:0]           c_next;
  logic                  v_acc;
  logic                  c_acc;

  // each group consumes 4*B message bits
  assign grp_off = 8'({words_q, 2'b00}) * 8'(grp);
  assign slice   = 16'(msg_buf >> grp_off);

  encode_seq_encode u_encode (
    .en    (1'b1),
    .level (lvl_q),
    .slice (slice),
    .enc   (enc)
  );

  always_comb begin
    c_next = '0;
    for (int i = 0; i < 4; i++) begin
      c_next[16*i +: 16] = v_data[16*i +: 16] + enc[16*i +: 16];
      if (lvl_q == LVL_640) c_next[16*i + 15] = 1'b0;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign v_ready = (state == ST_RUN) && (!c_valid || c_ready) && !v_all;
  assign v_acc   = v_valid && v_ready;
  assign c_acc   = c_valid && c_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lvl_q       <= LVL_INVALID;
      words_q     <= '0;
      ld_cnt      <= '0;
      grp         <= '0;
      c_cnt       <= '0;
      v_all       <= 1'b0;
      msg_buf     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      msg_rd_en   <= 1'b0;
      msg_rd_addr <= '0;
      c_valid     <= 1'b0;
      c_data      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (level == LVL_INVALID) begin
              err <= 1'b1;
            end else begin
              state       <= ST_LOAD;
              lvl_q       <= level;
              words_q     <= level_words(level);
              ld_cnt      <= '0;
              grp         <= '0;
              c_cnt       <= '0;
              v_all       <= 1'b0;
              msg_buf     <= '0;
              msg_rd_en   <= 1'b1;
              msg_rd_addr <= '0;
            end
          end
        end
        ST_LOAD: begin
          // data for the read issued in LOAD cycle k arrives in cycle k+1
          for (int k = 0; k < MSG_WORDS_MAX; k++) begin
            if (ld_cnt == 3'(k + 1)) msg_buf[64*k +: 64] <= msg_rd_data;
          end
          if (ld_cnt + 3'd1 < words_q) begin
            msg_rd_en   <= 1'b1;
            msg_rd_addr <= ld_cnt[1:0] + 2'd1;
          end else begin
            msg_rd_en   <= 1'b0;
            msg_rd_addr <= '0;
          end
          if (ld_cnt == words_q) state <= ST_RUN;
          ld_cnt <= ld_cnt + 3'd1;
        end
        ST_RUN: begin
          if (v_acc) begin
            c_data  <= c_next;
            c_valid <= 1'b1;
            if (grp == 4'd15) v_all <= 1'b1;
            else              grp   <= grp + 4'd1;
          end else if (c_acc) begin
            c_valid <= 1'b0;
          end
          if (c_acc) begin
            c_cnt <= c_cnt + 4'd1;
            if (c_cnt == 4'd15) begin
              state   <= ST_FIN;
              done    <= 1'b1;
              c_valid <= 1'b0;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_seq.sv
// tb/tb_encode_seq.sv - scoreboard bench for encode_seq
module tb_encode_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  level;
  logic        busy;
  logic        done;
  logic        err;
  logic        msg_rd_en;
  logic [1:0]  msg_rd_addr;
  logic [63:0] msg_rd_data;
  logic        v_valid;
  logic        v_ready;
  logic [63:0] v_data;
  logic        c_valid;
  logic        c_ready;
  logic [63:0] c_data;

  int checks;
  int failures;
  int rd_count;
  logic [63:0] mem [4];
  logic [63:0] vw [16];
  logic [63:0] exp_q [$];
  logic [63:0] first_beat;
  logic [63:0] last_beat;

  encode_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .level       (level),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .msg_rd_en   (msg_rd_en),
    .msg_rd_addr (msg_rd_addr),
    .msg_rd_data (msg_rd_data),
    .v_valid     (v_valid),
    .v_ready     (v_ready),
    .v_data      (v_data),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_data      (c_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (msg_rd_en) begin
      msg_rd_data <= mem[msg_rd_addr];
      rd_count    <= rd_count + 1;
    end
  end

  function automatic logic [63:0] model_c(input logic [1:0] lvl, input logic [255:0] flat,
                                          input logic [63:0] v, input int g);
    int b;
    logic [63:0] r;
    logic [15:0] bits;
    logic [15:0] lane;
    b = (lvl == 2'b01) ? 4 : (lvl == 2'b10) ? 3 : 2;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      bits = 16'(flat >> (4*b*g + b*i)) & 16'((1 << b) - 1);
      lane = v[16*i +: 16] + ((b == 4) ? (bits << 12) : (bits << 13));
      if (lvl == 2'b11) lane[15] = 1'b0;
      r[16*i +: 16] = lane;
    end
    return r;
  endfunction

  task automatic set_handshake(input int mode);
    if (mode == 1) begin
      v_valid = ($urandom_range(0, 3) != 0);
      c_ready = ($urandom_range(0, 3) != 0);
    end else begin
      v_valid = 1'b1;
      c_ready = 1'b1;
    end
  endtask

  task automatic run_block(input logic [1:0] lvl, input int mode, input int abort_after, input bit poke);
    int b, vidx, beats, cyc, first_c, last_c, stall_left, base_rd;
    bit stalled, hold, poked, vacc, cacc;
    logic [63:0] held, exp_c;
    logic [255:0] flat;
    b = (lvl == 2'b01) ? 4 : (lvl == 2'b10) ? 3 : 2;
    flat = {mem[3], mem[2], mem[1], mem[0]};
    exp_q.delete();
    for (int g = 0; g < 16; g++) exp_q.push_back(model_c(lvl, flat, vw[g], g));
    vidx = 0; beats = 0; cyc = 0; first_c = 0; last_c = 0; stall_left = 0;
    stalled = 0; hold = 0; poked = 0; held = '0;
    @(posedge clk); #1;
    base_rd = rd_count;
    start = 1'b1; level = lvl; v_data = vw[0];
    set_handshake(mode);
    @(posedge clk); #1;
    start = 1'b0;
    while (beats < 16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      vacc = v_valid && v_ready;
      cacc = c_valid && c_ready;
      if (hold) begin
        checks++;
        if (c_valid !== 1'b1 || c_data !== held)
          begin failures++; $display("FAIL c_hold: got valid=%b data=%h want valid=1 data=%h", c_valid, c_data, held); end
      end
      if (c_valid && !c_ready) begin
        checks++;
        if (v_ready !== 1'b0)
          begin failures++; $display("FAIL v_ready_stall: got %b want 0", v_ready); end
        held = c_data; hold = 1;
      end else begin
        hold = 0;
      end
      if (cacc) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL c_extra: got %h want no beat", c_data);
        end else begin
          exp_c = exp_q.pop_front();
          if (c_data !== exp_c)
            begin failures++; $display("FAIL c_beat%0d: got %h want %h", beats, c_data, exp_c); end
        end
        if (beats == 0) begin first_c = cyc; first_beat = c_data; end
        last_c = cyc; last_beat = c_data;
        beats++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (abort_after > 0 && beats == abort_after) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, msg_rd_en, v_ready, c_valid} !== 6'b0 || msg_rd_addr !== 2'b0 || c_data !== 64'h0)
          begin failures++; $display("FAIL mid_reset: got busy=%b done=%b err=%b rd=%b addr=%h vr=%b cv=%b cd=%h want all 0",
                                     busy, done, err, msg_rd_en, msg_rd_addr, v_ready, c_valid, c_data); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (vacc) begin
        vidx++;
        v_data = (vidx < 16) ? vw[vidx] : 64'h0;
      end
      if (poke && !poked && beats == 3) begin start = 1'b1; level = 2'b01; poked = 1; end
      if (mode == 2) begin
        v_valid = 1'b1;
        if (!stalled && beats >= 5) begin stalled = 1; stall_left = 5; end
        c_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        set_handshake(mode);
      end
    end
    checks++;
    if (beats != 16) begin failures++; $display("FAIL beat_count: got %0d want 16", beats); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1)
      begin failures++; $display("FAIL done_pulse: got done=%b busy=%b want 1 1", done, busy); end
    checks++;
    if (rd_count - base_rd != b)
      begin failures++; $display("FAIL read_count: got %0d want %0d", rd_count - base_rd, b); end
    if (mode == 0) begin
      checks++;
      if (last_c - first_c != 15)
        begin failures++; $display("FAIL no_bubbles: got span %0d want 15", last_c - first_c); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL fin_to_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic randomize_block(input logic [63:0] vmask);
    for (int k = 0; k < 4; k++) mem[k] = {$urandom, $urandom};
    for (int g = 0; g < 16; g++) vw[g] = {$urandom, $urandom} & vmask;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; level = 2'b00; v_valid = 1'b0; v_data = '0; c_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, msg_rd_en, v_ready, c_valid} !== 6'b0)
      begin failures++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, msg_rd_en, v_ready, c_valid}); end
    checks++;
    if (msg_rd_addr !== 2'b0 || c_data !== 64'h0)
      begin failures++; $display("FAIL reset_data: got addr=%h c=%h want 0 0", msg_rd_addr, c_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_err;
    int base_rd;
    @(posedge clk); #1;
    base_rd = rd_count;
    start = 1'b1; level = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || msg_rd_en !== 1'b0)
      begin failures++; $display("FAIL err_pulse: got err=%b busy=%b rd=%b want 1 0 0", err, busy, msg_rd_en); end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || rd_count != base_rd)
      begin failures++; $display("FAIL err_clear: got err=%b busy=%b reads=%0d want 0 0 0", err, busy, rd_count - base_rd); end
  endtask

  task automatic test_all_ones;
    for (int k = 0; k < 4; k++) mem[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int g = 0; g < 16; g++) vw[g] = 64'h0001_0001_0001_0001;
    run_block(2'b01, 0, 0, 0);
    checks++;
    if (last_beat !== 64'hF001_F001_F001_F001)
      begin failures++; $display("FAIL all_ones_lane: got %h want f001f001f001f001", last_beat); end
  endtask

  task automatic test_level3;
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    mem[0][7:0] = 8'hE4;
    for (int g = 0; g < 16; g++) vw[g] = 64'h7FFF_7FFF_7FFF_7FFF;
    run_block(2'b11, 1, 0, 0);
    checks++;
    if (first_beat !== 64'h5FFF_3FFF_1FFF_7FFF)
      begin failures++; $display("FAIL level3_first: got %h want 5fff3fff1fff7fff", first_beat); end
  endtask

  task automatic test_stall;
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    run_block(2'b10, 2, 0, 1);
  endtask

  task automatic test_reset_mid;
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    run_block(2'b01, 1, 7, 0);
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    run_block(2'b10, 1, 0, 0);
  endtask

  task automatic test_back_to_back;
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    run_block(2'b11, 0, 0, 0);
    randomize_block(64'hFFFF_FFFF_FFFF_FFFF);
    run_block(2'b01, 1, 0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_err();
    test_all_ones();
    test_level3();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
